// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage for the WISC CPU. It owns the PC, fetches from a
// variable-latency instruction memory over a req/rdy handshake, and holds one
// fetched instruction for decode under a valid/stall handshake. It also takes
// branch redirects and stops fetching once a HLT instruction is captured.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, two saturating 32-bit performance counters are added:
//     perf_fetched : +1 for every instruction captured from memory
//     perf_stall   : +1 for every cycle with if_valid=1 and stall=1
//   When undefined, these ports and counters do not exist.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst             in   synchronous active-high reset
//   stall           in   decode cannot accept if_instr this cycle
//   redirect_valid  in   taken branch/jump, load redirect_pc
//   redirect_pc     in   redirect target address
//   imem_req        out  fetch request to instruction memory
//   imem_addr       out  fetch address (equals pc)
//   imem_rdy        in   imem_rdata valid this cycle (only while imem_req=1)
//   imem_rdata      in   fetched instruction word
//   if_valid        out  if_instr / if_pc hold a valid instruction
//   if_instr        out  buffered instruction
//   if_pc           out  address of if_instr
//   if_pc_plus      out  if_pc + PC_STEP, wrapping at ADDR_W bits
//   pc              out  current fetch PC
//   hlt             out  fetch halted on HLT_OPCODE
//   perf_fetched    out  (FETCH_PERF_CNT_EN only) captured instruction count
//   perf_stall      out  (FETCH_PERF_CNT_EN only) stalled-with-valid cycles
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              ADDR_W     = 16,
    parameter int              INSTR_W    = 16,
    parameter int              PC_STEP    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus,
    output logic [ADDR_W-1:0]  pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               hlt
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;

    logic req;
    logic capture;

    // Next-state logic. Priority: redirect > capture > drain of a consumed slot.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        req        = 1'b0;

        // A request is only made when the slot will be free at the next edge:
        // either it is empty, or decode takes its contents this cycle. Reset
        // and redirect both drop any outstanding request immediately.
        if (state_q == S_FETCH && !redirect_valid && !rst) begin
            req = !if_valid_q || !stall;
        end
        capture = req && imem_rdy;

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            state_d    = S_FETCH;
        end else if (capture) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            // HLT keeps pc pointing at itself so a debugger sees where it stopped.
            if (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE) begin
                state_d = S_HALTED;
            end else begin
                pc_d = pc_q + STEP;
            end
        end else if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        imem_req   = req;
        imem_addr  = pc_q;
        if_valid   = if_valid_q;
        if_instr   = if_instr_q;
        if_pc      = if_pc_q;
        if_pc_plus = if_pc_q + STEP;
        pc         = pc_q;
        hlt        = (state_q == S_HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (capture && perf_fetched_q != 32'hFFFF_FFFF) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (if_valid_q && stall && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    always_comb begin
        perf_fetched = perf_fetched_q;
        perf_stall   = perf_stall_q;
    end
`endif

endmodule
